fifo_flex: RTL and testbench
============================

FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, giving the pointer width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 The block SHALL have parameter FWFT, default 0, where 0 selects registered-read mode and 1 selects first-word-fall-through mode.
REQ-004 The block SHALL have parameter AFULL_LVL, default DEPTH-2, as the almost_full threshold in entries.
REQ-005 The block SHALL have parameter AEMPTY_LVL, default 2, as the almost_empty threshold in entries.
REQ-006 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-high.
REQ-008 push  input  1  write request.
REQ-009 pop  input  1  read request.
REQ-010 flush  input  1  synchronous clear of contents.
REQ-011 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-012 data_in  input  DATA_WIDTH  write data.
REQ-013 data_out  output  DATA_WIDTH  read data.
REQ-014 count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
REQ-015 empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 A push SHALL be accepted iff push=1 and full=0; a pop SHALL be accepted iff pop=1 and empty=0.
REQ-018 An accepted push SHALL write data_in to mem[wr_ptr] and increment wr_ptr modulo DEPTH.
REQ-019 An accepted pop SHALL increment rd_ptr modulo DEPTH; pointer wrap from DEPTH-1 to 0 SHALL be seamless.
REQ-020 count SHALL be +1 on push only, -1 on pop only, and unchanged when both or neither are accepted.
REQ-021 Simultaneous push and pop while empty SHALL accept only the push; while full, only the pop.
REQ-022 empty = (count==0), full = (count==DEPTH), almost_empty = (count<=AEMPTY_LVL), almost_full = (count>=AFULL_LVL); all SHALL be decoded from registered count and are valid the cycle after the edge.
REQ-023 With FWFT=0, data_out SHALL register mem[rd_ptr] on the edge accepting a pop (1-cycle latency) and otherwise hold its value.
REQ-024 With FWFT=1, data_out SHALL continuously equal mem[rd_ptr] while empty=0 (the first word is visible the cycle after the push that fills an empty FIFO); its value while empty=1 is don't-care.
REQ-025 A push with full=1 SHALL set overflow; a pop with empty=1 SHALL set underflow; neither SHALL change pointers, count, memory or data_out.
REQ-026 overflow and underflow SHALL remain set until clr_err=1 or reset; if clr_err and a new error occur in the same cycle, the flag SHALL be 1.
REQ-027 flush=1 SHALL zero wr_ptr, rd_ptr and count and set data_out to 0 at the next edge, taking priority over push and pop in that cycle; memory contents are not cleared and error flags are unaffected.
REQ-028 A register-mode pop of the entry being written in the same cycle is impossible, since push and pop are accepted together only when count>=1, and SHALL need no bypass.

Reset
REQ-029 rst_n=1 SHALL immediately, without a clock, force wr_ptr=0, rd_ptr=0, count=0, data_out=0, overflow=0 and underflow=0, so that empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-030 Assertion of rst_n mid-operation SHALL discard all stored entries; memory array contents need not be reset.

Verification
REQ-031 Defaults, FWFT=0: push 0x01..0x10 on 16 cycles -> count=16, full=1 and almost_full=1 from count 14; then 16 pops -> data_out 0x01..0x10 each one cycle after its pop; empty=1 at end.
REQ-032 Wrap-around: push 10, pop 10, push 12, pop 12 with data 0xA0+i -> in-order data, empty=1 at end, no errors.
REQ-033 Full with push=1, pop=1 and data 0x55 -> pop accepted, 0x55 dropped, count=15, overflow stays 0; next cycle push=1 alone, nothing popped -> count=16; further push=1 with full=1 -> overflow=1 until clr_err.
REQ-034 FWFT=1: push 0x3C into empty FIFO -> data_out=0x3C the next cycle with no pop; pop -> empty=1.
REQ-035 Pop while empty -> underflow=1, count=0, data_out unchanged; flush with count=5 -> count=0, empty=1, data_out=0 after one edge.
REQ-036 Async rst_n pulse between clock edges with count=7 -> count=0, empty=1 and data_out=0 immediately, before the next edge.

Source files
------------

// File: rtl/fifo_flex.sv
// rtl/fifo_flex.sv - parameterised FIFO with registered-read or first-word-fall-through output
module fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter bit FWFT       = 1'b0,
  parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LVL);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  push_ok, pop_ok;

  // Status flags are decoded from the registered count only.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign almost_full  = (count_q >= AFULL_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok && !pop_ok) count_d = count_q + CNT_ONE;
      else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
    end
  end

  // A push dropped while a pop frees a slot (and vice versa) is not an error.
  always_comb begin
    ovf_d = (ovf_q & ~clr_err) | (push & full & ~pop_ok);
    udf_d = (udf_q & ~clr_err) | (pop & empty & ~push_ok);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] data_q, data_d;

      always_comb begin
        data_d = data_q;
        if (flush) data_d = '0;
        else if (pop_ok) data_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) data_q <= '0;
        else       data_q <= data_d;
      end

      assign data_out = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// tb/tb_fifo_flex.sv - vector-table bench for fifo_flex in registered and FWFT modes
module tb_fifo_flex;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       push = 1'b0, pop = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout0, dout1;
  logic [4:0] cnt0, cnt1;
  logic       e0, f0, ae0, af0, ov0, ud0;
  logic       e1, f1, ae1, af1, ov1, ud1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_flex #(.FWFT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
    .data_in(data_in), .data_out(dout0), .count(cnt0), .empty(e0), .full(f0),
    .almost_empty(ae0), .almost_full(af0), .overflow(ov0), .underflow(ud0)
  );

  fifo_flex #(.FWFT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
    .data_in(data_in), .data_out(dout1), .count(cnt1), .empty(e1), .full(f1),
    .almost_empty(ae1), .almost_full(af1), .overflow(ov1), .underflow(ud1)
  );

  typedef struct {
    logic       push, pop, flush, clr;
    logic [7:0] din;
    int         cnt;
    logic [7:0] dout;
    logic       ovf, udf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic p, input logic q, input logic fl, input logic cl,
                              input int din, input int cnt, input int dout,
                              input logic ovf, input logic udf);
    vec_t v;
    v.push = p; v.pop = q; v.flush = fl; v.clr = cl;
    v.din = din[7:0]; v.cnt = cnt; v.dout = dout[7:0]; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endfunction

  task automatic check_status(input string name, input int cnt, input int dout,
                              input logic ovf, input logic udf);
    logic ee, ef, eae, eaf;
    ee = (cnt == 0); ef = (cnt == 16); eae = (cnt <= 2); eaf = (cnt >= 14);
    n_vec++;
    if (cnt0 !== cnt[4:0] || dout0 !== dout[7:0] || e0 !== ee || f0 !== ef ||
        ae0 !== eae || af0 !== eaf || ov0 !== ovf || ud0 !== udf) begin
      n_bad++;
      $display("FAIL %s: got cnt=%0d dout=%02h e/f/ae/af/ov/ud=%b%b%b%b%b%b, need cnt=%0d dout=%02h e/f/ae/af/ov/ud=%b%b%b%b%b%b",
               name, cnt0, dout0, e0, f0, ae0, af0, ov0, ud0,
               cnt, dout[7:0], ee, ef, eae, eaf, ovf, udf);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, need %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic fl, input logic cl, input int din);
    @(negedge clk);
    push = p; pop = q; flush = fl; clr_err = cl; data_in = din[7:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Deep fill then drain.
    for (int i = 0; i < 16; i++) add(1, 0, 0, 0, i + 1, i + 1, 0, 0, 0);
    for (int j = 0; j < 16; j++) add(0, 1, 0, 0, 0, 15 - j, j + 1, 0, 0);
    // Pop while empty, then clear the sticky flag.
    add(0, 1, 0, 0, 0, 0, 8'h10, 0, 1);
    add(0, 0, 0, 0, 0, 0, 8'h10, 0, 1);
    add(0, 0, 0, 1, 0, 0, 8'h10, 0, 0);
    // Flush with five entries held.
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 8'h21 + i, i + 1, 8'h10, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Wrap-around.
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 8'hA0 + i, i + 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 0, 9 - i, 8'hA0 + i, 0, 0);
    for (int i = 0; i < 12; i++) add(1, 0, 0, 0, 8'hA0 + i, i + 1, 8'hA9, 0, 0);
    for (int i = 0; i < 12; i++) add(0, 1, 0, 0, 0, 11 - i, 8'hA0 + i, 0, 0);
    // Full: simultaneous push/pop drops the push, then overflow handling.
    for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 8'h60 + i, i + 1, 8'hAB, 0, 0);
    add(1, 1, 0, 0, 8'h55, 15, 8'h60, 0, 0);
    add(1, 0, 0, 0, 8'h77, 16, 8'h60, 0, 0);
    add(1, 0, 0, 0, 8'h99, 16, 8'h60, 1, 0);
    add(0, 0, 0, 0, 0, 16, 8'h60, 1, 0);
    add(0, 0, 0, 1, 0, 16, 8'h60, 0, 0);
    for (int j = 0; j < 15; j++) add(0, 1, 0, 0, 0, 15 - j, 8'h61 + j, 0, 0);
    add(0, 1, 0, 0, 0, 0, 8'h77, 0, 0);

    #12;
    check_status("reset_state", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].push, vecs[k].pop, vecs[k].flush, vecs[k].clr, int'(vecs[k].din));
      check_status($sformatf("vec%0d", k), vecs[k].cnt, int'(vecs[k].dout), vecs[k].ovf, vecs[k].udf);
    end

    // Asynchronous reset between edges with seven entries held.
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'h81 + i);
    step(0, 1, 0, 0, 0);
    check_status("pre_async_rst", 7, 8'h81, 0, 0);
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    chk("async_rst_count", int'(cnt0), 0);
    chk("async_rst_empty", int'(e0), 1);
    chk("async_rst_dout", int'(dout0), 0);
    chk("async_rst_full", int'(f0), 0);
    #1 rst_n = 1'b0;

    // First-word-fall-through instance.
    step(1, 0, 0, 0, 8'h3C);
    chk("fwft_first_word", int'(dout1), 8'h3C);
    chk("fwft_count1", int'(cnt1), 1);
    chk("reg_no_pop_dout", int'(dout0), 0);
    step(0, 1, 0, 0, 0);
    chk("fwft_empty_after_pop", int'(e1), 1);
    chk("reg_dout_after_pop", int'(dout0), 8'h3C);
    step(1, 0, 0, 0, 8'h11);
    step(1, 0, 0, 0, 8'h22);
    chk("fwft_head_held", int'(dout1), 8'h11);
    step(0, 1, 0, 0, 0);
    chk("fwft_next_head", int'(dout1), 8'h22);
    chk("fwft_count_after", int'(cnt1), 1);
    step(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
